seg_scan_driver: RTL
====================

// Module: seg_scan_driver
// PURPOSE
//  Upstream stage of the 7-segment decoder: time-multiplexes NDIG packed 4-bit digits onto the
//  decoder's single data/mode/en input, one digit per scan slot, and drives one-hot digit select.
//  Double-buffers incoming values so a frame never tears, and blanks leading zeros.
// PARAMETERS
//  NDIG  4      number of digits scanned (2..8); digit 0 = rightmost/least significant
//  DIV   50000  clk cycles per digit slot (>=2)
// PORTS
//  clk      in   1        system clock, rising edge
//  rst      in   1        asynchronous, active-high reset
//  digits   in   4*NDIG   packed digit values, digit i = digits[4*i+3:4*i]
//  load     in   1        1-cycle strobe: capture digits for display
//  hexmode  in   1        1: show 0-F; 0: BCD, codes A-F shown blank
//  blank_en in   1        1: enable leading-zero blanking
//  data     out  4        current digit value to decoder
//  mode     out  2        decoder mode: 2'b11 if hexmode else 2'b01
//  en       out  1        decoder enable; 0 = segments off this slot
//  dig_sel  out  NDIG     digit select, one-hot active-low
//  frame    out  1        1-cycle pulse when scan wraps NDIG-1 -> 0
// BEHAVIOUR
//  - Reset (async): presc=0, idx=0, hold=0, pending=0, shadow=0; outputs data=0, mode=2'b01,
//    en=0, dig_sel=all ones, frame=0. Release on first clk edge with rst low.
//  - Prescaler presc counts 0..DIV-1, wraps; terminal count (tc) when presc==DIV-1.
//  - On tc: idx <= (idx==NDIG-1) ? 0 : idx+1. On tc with idx==NDIG-1: wrap event.
//  - All outputs registered; they reflect the new idx one cycle after tc (the same edge idx
//    updates). frame=1 on the edge the outputs switch to digit 0, 0 otherwise.
//  - load: hold <= digits, pending <= 1. Multiple loads within a frame: last one wins.
//  - On wrap: if load in the same cycle, shadow <= digits directly; else if pending,
//    shadow <= hold; pending <= 0 in both cases. shadow never changes mid-frame.
//  - Output for slot idx: data = shadow digit idx; dig_sel = ~(1<<idx);
//    mode = hexmode ? 2'b11 : 2'b01 (sampled every cycle, registered).
//  - Blanking: digit i is blanked if blank_en && i!=0 && shadow digits i..NDIG-1 all zero.
//    en = ~blank; digit 0 is never blanked (value 0 shows "0").
//  - BCD mode with digit >9: en stays 1, decoder mode 01 renders blank; no extra handling.
//  - hexmode/blank_en changes take effect on the next registered output update, even mid-frame.
//  - rst mid-frame: everything returns to reset values immediately; pending load is discarded.
// CONFIGURATION
//  SEG_SCAN_DIM_EN defined: extra input bright [1:0] (brightness). Within each slot, en is
//    forced 0 when presc >= ((bright+1)*DIV)/4 (25/50/75/100% duty); blanking still applies.
//    Output is registered and stays 0 when blanked.
//  Not defined: no bright port; en held for the whole slot.
// TESTING (NDIG=4, DIV=4)
//  1 reset held, then released -> dig_sel=4'b1111, en=0 until first tc; then idx steps 0,1,2,3,0
//    every 4 clks, dig_sel 1110,1101,1011,0111, frame pulses once per 16 clks.
//  2 load digits=16'h1234 mid-frame -> data unchanged until frame; next frame data=4,3,2,1.
//  3 digits=16'h0050, blank_en=1 -> en per slot 1,1,0,0 (digit 3,2 blank);
//    digits=16'h0000 -> en=1,0,0,0, data=0.
//  4 load 16'h1111 then 16'h2222 in same frame -> next frame shows 2; load coincident with wrap
//    cycle -> that value shows in the frame starting then.
//  5 hexmode=1, digits=16'hABCD -> mode=2'b11, data D,C,B,A; hexmode=0 -> mode=2'b01.
//  6 rst asserted mid-slot with pending load -> outputs reset immediately; after release shadow=0.
//    With SEG_SCAN_DIM_EN, bright=2'b01 -> en high 2 of 4 clks per slot.

Source files
------------

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - multiplexed digit scan driver feeding a 7-segment decoder (optional dimming via SEG_SCAN_DIM_EN)
module seg_scan_driver #(
    parameter int NDIG = 4,
    parameter int DIV  = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4*NDIG-1:0] digits,
    input  logic              load,
    input  logic              hexmode,
    input  logic              blank_en,
`ifdef SEG_SCAN_DIM_EN
    input  logic [1:0]        bright,
`endif
    output logic [3:0]        data,
    output logic [1:0]        mode,
    output logic              en,
    output logic [NDIG-1:0]   dig_sel,
    output logic              frame
);

    localparam int PW = $clog2(DIV);
    localparam int IW = $clog2(NDIG);

    logic [PW-1:0]     presc;
    logic [PW-1:0]     presc_nxt;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     idx_nxt;
    logic              tc;
    logic              wrap;
    logic [4*NDIG-1:0] hold;
    logic [4*NDIG-1:0] shadow;
    logic [4*NDIG-1:0] shadow_nxt;
    logic              pending;
    logic              blank;
    logic              nonzero;
    logic [3:0]        digit_nxt;
    logic [NDIG-1:0]   sel_nxt;

`ifdef SEG_SCAN_DIM_EN
    logic run;
    logic lit;
    int   thr;
`endif

    // Slot timing, next-frame buffer selection and blanking for the slot about to be shown.
    always_comb begin
        tc         = (presc == PW'(DIV - 1));
        presc_nxt  = tc ? '0 : presc + 1'b1;
        wrap       = tc && (idx == IW'(NDIG - 1));
        idx_nxt    = idx;
        shadow_nxt = shadow;
        if (tc) begin
            idx_nxt = wrap ? '0 : idx + 1'b1;
        end
        // A load landing on the wrap cycle takes priority over an older pending value.
        if (wrap) begin
            if (load) begin
                shadow_nxt = digits;
            end else if (pending) begin
                shadow_nxt = hold;
            end
        end
        digit_nxt = shadow_nxt[4*idx_nxt +: 4];
        sel_nxt   = ~(NDIG'(1) << idx_nxt);
        // A digit is a leading zero when it and every more significant digit are zero.
        nonzero   = 1'b0;
        for (int j = 0; j < NDIG; j++) begin
            if (j >= int'(idx_nxt) && shadow_nxt[4*j +: 4] != 4'd0) begin
                nonzero = 1'b1;
            end
        end
        blank = blank_en && (idx_nxt != '0) && !nonzero;
`ifdef SEG_SCAN_DIM_EN
        thr = ((int'(bright) + 1) * DIV) / 4;
        lit = (int'(presc_nxt) < thr);
`endif
    end

    // Prescaler, scan index and the hold/shadow double buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc   <= '0;
            idx     <= '0;
            hold    <= '0;
            pending <= 1'b0;
            shadow  <= '0;
        end else begin
            presc  <= presc_nxt;
            idx    <= idx_nxt;
            shadow <= shadow_nxt;
            if (load) begin
                hold    <= digits;
                pending <= 1'b1;
            end
            if (wrap) begin
                pending <= 1'b0;
            end
        end
    end

    // Registered decoder-facing outputs; slot outputs move on the same edge as idx.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data    <= 4'd0;
            mode    <= 2'b01;
            en      <= 1'b0;
            dig_sel <= '1;
            frame   <= 1'b0;
`ifdef SEG_SCAN_DIM_EN
            run     <= 1'b0;
`endif
        end else begin
            mode  <= hexmode ? 2'b11 : 2'b01;
            frame <= wrap;
            if (tc) begin
                data    <= digit_nxt;
                dig_sel <= sel_nxt;
            end
`ifdef SEG_SCAN_DIM_EN
            // Duty gating is re-evaluated every cycle once scanning has started.
            if (tc) begin
                run <= 1'b1;
            end
            en <= (run || tc) && !blank && lit;
`else
            if (tc) begin
                en <= !blank;
            end
`endif
        end
    end

endmodule
